program_loader: RTL and testbench



---
 rtl/program_loader.sv | 170 +++++++++++++++++
 tb/tb_program_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: receives a framed byte stream, writes big-endian 16-bit words into
// BRAM port B and holds the CPU in reset until a checksum-valid image has loaded.
`timescale 1ns/1ps

module program_loader #(
    parameter logic [15:0] BASE_ADDR      = 16'h0000,
    parameter int unsigned MAX_WORDS      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] data_b,
    output logic [15:0] addr_b,
    output logic        we_b,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [7:0]    len_hi;
    logic [15:0]   n_words;
    logic [7:0]    word_hi;
    logic [7:0]    acc;
    logic [15:0]   idx;
    logic [TW-1:0] tmo_cnt;

    logic          accept_c;
    logic          load_start_c;
    logic          timed_c;
    logic          rx_next_c;
    logic [15:0]   n_full_c;
    logic [15:0]   idx_inc_c;

    // Next-state decode; timeout overrides the normal transition in waiting states.
    always_comb begin
        state_next   = state;
        load_start_c = 1'b0;
        accept_c     = rx_valid && rx_ready;
        n_full_c     = {len_hi, rx_data};
        idx_inc_c    = idx + 16'd1;
        timed_c      = (state == S_LEN_LO) || (state == S_DATA_HI) ||
                       (state == S_DATA_LO) || (state == S_CHK);

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_next   = S_LEN_HI;
                    load_start_c = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (accept_c) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept_c) begin
                    if (n_full_c == 16'd0 || 32'(n_full_c) > MAX_WORDS)
                        state_next = S_ERROR;
                    else
                        state_next = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (accept_c) state_next = S_DATA_LO;
            end
            S_DATA_LO: begin
                if (accept_c) state_next = S_WRITE;
            end
            S_WRITE: begin
                state_next = (idx_inc_c == n_words) ? S_CHK : S_DATA_HI;
            end
            S_CHK: begin
                if (accept_c) state_next = (rx_data == acc) ? S_DONE : S_ERROR;
            end
            default: state_next = S_IDLE;
        endcase

        if (timed_c && !accept_c && tmo_cnt == TW'(TIMEOUT_CYCLES - 1))
            state_next = S_ERROR;

        rx_next_c = (state_next == S_LEN_HI) || (state_next == S_LEN_LO) ||
                    (state_next == S_DATA_HI) || (state_next == S_DATA_LO) ||
                    (state_next == S_CHK);
    end

    // State, datapath and registered outputs (outputs track the state being entered).
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            len_hi       <= 8'd0;
            n_words      <= 16'd0;
            word_hi      <= 8'd0;
            acc          <= 8'd0;
            idx          <= 16'd0;
            tmo_cnt      <= '0;
            rx_ready     <= 1'b0;
            data_b       <= 16'd0;
            addr_b       <= 16'd0;
            we_b         <= 1'b0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            state     <= state_next;
            rx_ready  <= rx_next_c;
            busy      <= rx_next_c || (state_next == S_WRITE);
            done      <= (state_next == S_DONE);
            error     <= (state_next == S_ERROR);
            cpu_reset <= (state_next != S_DONE);
            we_b      <= (state_next == S_WRITE);

            if (!timed_c || accept_c)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);

            if (load_start_c) begin
                acc          <= 8'd0;
                idx          <= 16'd0;
                words_loaded <= 16'd0;
            end

            if (accept_c && state != S_CHK)
                acc <= acc ^ rx_data;

            if (accept_c && state == S_LEN_HI)
                len_hi <= rx_data;
            if (accept_c && state == S_LEN_LO)
                n_words <= n_full_c;
            if (accept_c && state == S_DATA_HI)
                word_hi <= rx_data;

            // Word is presented to port B in the cycle after its low byte arrives.
            if (accept_c && state == S_DATA_LO) begin
                data_b <= {word_hi, rx_data};
                addr_b <= BASE_ADDR + idx;
            end

            if (state == S_WRITE) begin
                idx          <= idx_inc_c;
                words_loaded <= words_loaded + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal load, checksum/length errors,
// flow control, inter-byte timeout and reset/restart.
`timescale 1ns/1ps

module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] data_b;
    logic [15:0] addr_b;
    logic        we_b;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    always #5 clk = ~clk;

    program_loader #(
        .BASE_ADDR      (16'h0000),
        .MAX_WORDS      (1024),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .data_b       (data_b),
        .addr_b       (addr_b),
        .we_b         (we_b),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic        wr_rdy_q[$];
    logic [7:0]  frame_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Record every port-B write together with rx_ready in that cycle.
    always @(negedge clk) begin
        if (we_b === 1'b1) begin
            wr_addr_q.push_back(addr_b);
            wr_data_q.push_back(data_b);
            wr_rdy_q.push_back(rx_ready);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_rdy_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) tick();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && waited < 64) begin
            tick();
            waited++;
        end
        if (rx_ready !== 1'b1) check("accept_wait", 32'(rx_ready), 32'd1);
        else tick();
    endtask

    task automatic send_frame(input int gap);
        foreach (frame_q[i]) send_byte(frame_q[i], (i == 0) ? 0 : gap);
        rx_valid = 1'b0;
    endtask

    task automatic check_normal_writes(input string p);
        check({p, "_wr_count"}, 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check({p, "_wr0_addr"}, 32'(wr_addr_q[0]), 32'h0000);
            check({p, "_wr0_data"}, 32'(wr_data_q[0]), 32'h1234);
            check({p, "_wr1_addr"}, 32'(wr_addr_q[1]), 32'h0001);
            check({p, "_wr1_data"}, 32'(wr_data_q[1]), 32'hABCD);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) tick();

        check("rst_rx_ready",  32'(rx_ready),     32'd0);
        check("rst_we_b",      32'(we_b),         32'd0);
        check("rst_data_b",    32'(data_b),       32'd0);
        check("rst_addr_b",    32'(addr_b),       32'd0);
        check("rst_cpu_reset", 32'(cpu_reset),    32'd1);
        check("rst_busy",      32'(busy),         32'd0);
        check("rst_done",      32'(done),         32'd0);
        check("rst_error",     32'(error),        32'd0);
        check("rst_words",     32'(words_loaded), 32'd0);
        reset = 1'b0;
        tick();

        // Normal load, back-to-back bytes with rx_valid held high across WRITE.
        clear_writes();
        pulse_start();
        check("norm_busy_on",  32'(busy),      32'd1);
        check("norm_rdy_on",   32'(rx_ready),  32'd1);
        check("norm_cpu_held", 32'(cpu_reset), 32'd1);
        frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_frame(0);
        check("norm_done",      32'(done),         32'd1);
        check("norm_error",     32'(error),        32'd0);
        check("norm_cpu_reset", 32'(cpu_reset),    32'd0);
        check("norm_busy_off",  32'(busy),         32'd0);
        check("norm_words",     32'(words_loaded), 32'd2);
        check("norm_hold_data", 32'(data_b),       32'hABCD);
        check("norm_hold_addr", 32'(addr_b),       32'h0001);
        check_normal_writes("norm");
        foreach (wr_rdy_q[i]) check("norm_rdy_in_write", 32'(wr_rdy_q[i]), 32'd0);

        // Bad checksum: writes still happen, load flagged as failed.
        clear_writes();
        pulse_start();
        check("badchk_cpu_reset_on_start", 32'(cpu_reset), 32'd1);
        check("badchk_done_cleared",       32'(done),      32'd0);
        frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        send_frame(0);
        check("badchk_error",     32'(error),     32'd1);
        check("badchk_done",      32'(done),      32'd0);
        check("badchk_cpu_reset", 32'(cpu_reset), 32'd1);
        check_normal_writes("badchk");

        // Zero length.
        clear_writes();
        pulse_start();
        check("len0_error_cleared", 32'(error), 32'd0);
        frame_q = '{8'h00, 8'h00};
        send_frame(0);
        check("len0_error",  32'(error), 32'd1);
        check("len0_busy",   32'(busy),  32'd0);
        tick();
        check("len0_no_write", 32'(wr_addr_q.size()), 32'd0);

        // Length 1025 exceeds MAX_WORDS.
        pulse_start();
        frame_q = '{8'h04, 8'h01};
        send_frame(0);
        check("len1025_error", 32'(error),        32'd1);
        check("len1025_words", 32'(words_loaded), 32'd0);
        tick();
        check("len1025_no_write", 32'(wr_addr_q.size()), 32'd0);

        // Flow control: three idle cycles between every byte.
        clear_writes();
        pulse_start();
        frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_frame(3);
        check("flow_done",      32'(done),         32'd1);
        check("flow_cpu_reset", 32'(cpu_reset),    32'd0);
        check("flow_words",     32'(words_loaded), 32'd2);
        check_normal_writes("flow");

        // Timeout: stall after the first data high byte.
        pulse_start();
        frame_q = '{8'h00, 8'h01, 8'h12};
        send_frame(0);
        repeat (15) tick();
        check("tmo_not_yet_error", 32'(error), 32'd0);
        check("tmo_not_yet_busy",  32'(busy),  32'd1);
        tick();
        check("tmo_error", 32'(error), 32'd1);
        check("tmo_busy",  32'(busy),  32'd0);

        // Reset after the first word is written, then a full reload.
        clear_writes();
        pulse_start();
        frame_q = '{8'h00, 8'h02, 8'h12, 8'h34};
        send_frame(0);
        tick();
        check("rstmid_words_before", 32'(words_loaded),      32'd1);
        check("rstmid_one_write",    32'(wr_addr_q.size()),  32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_cpu_reset", 32'(cpu_reset),    32'd1);
        check("rstmid_words",     32'(words_loaded), 32'd0);
        check("rstmid_busy",      32'(busy),         32'd0);
        check("rstmid_rx_ready",  32'(rx_ready),     32'd0);
        tick();

        pulse_start();
        frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_frame(0);
        check("restart_done",      32'(done),      32'd1);
        check("restart_cpu_reset", 32'(cpu_reset), 32'd0);

        pulse_start();
        check("redo_cpu_reset", 32'(cpu_reset), 32'd1);
        check("redo_done",      32'(done),      32'd0);
        check("redo_busy",      32'(busy),      32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
